// File: rtl/cc_arb_pkg.sv
// Shared widths, FSM states and the round-robin pick
// for the two-requester coordinate-engine arbiter.
package cc_arb_pkg;

   localparam int BEATS   = 4;
   localparam int MODE_W  = 2;
   localparam int COORD_W = 8;
   localparam int IDX_W   = $clog2(BEATS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_STREAM
   } state_e;

   // Favour the requester not granted last when both wait
   function automatic logic rr_pick(
      input logic f0,
      input logic f1,
      input logic last
   );
      if (f0 && f1) return ~last;
      return f1;
   endfunction

endpackage

// File: rtl/req_buffer.sv
// One requester's 4-beat job store: beat counter, mode latch,
// full flag; a job cut short before beat 4 is dropped.
module req_buffer
   import cc_arb_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               valid_i,
   input  logic [MODE_W-1:0]  mode_i,
   input  logic [COORD_W-1:0] x_i,
   input  logic [COORD_W-1:0] y_i,
   input  logic               free_i,
   input  logic [IDX_W-1:0]   rd_idx_i,
   output logic               ready_o,
   output logic               full_o,
   output logic [MODE_W-1:0]  mode_o,
   output logic [COORD_W-1:0] rd_x_o,
   output logic [COORD_W-1:0] rd_y_o
);

   logic [IDX_W-1:0]   cnt_q, cnt_d;
   logic               full_q, full_d;
   logic [MODE_W-1:0]  mode_q, mode_d;
   logic [COORD_W-1:0] x_q [BEATS];
   logic [COORD_W-1:0] y_q [BEATS];
   logic               load;

   assign load    = valid_i && !full_q;
   assign ready_o = !full_q;
   assign full_o  = full_q;
   assign mode_o  = mode_q;
   assign rd_x_o  = x_q[rd_idx_i];
   assign rd_y_o  = y_q[rd_idx_i];

   // Beat counting, mode capture on beat 0, full on beat 3
   always_comb begin
      cnt_d  = cnt_q;
      full_d = full_q;
      mode_d = mode_q;
      if (full_q) begin
         if (free_i) full_d = 1'b0;
      end else if (valid_i) begin
         if (cnt_q == '0) mode_d = mode_i;
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == IDX_W'(BEATS - 1)) full_d = 1'b1;
      end else begin
         cnt_d = '0;
      end
   end

   // Control state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         full_q <= 1'b0;
         mode_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         full_q <= full_d;
         mode_q <= mode_d;
      end
   end

   // Capture each accepted beat into its slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BEATS; i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
         end
      end else if (load) begin
         x_q[cnt_q] <= x_i;
         y_q[cnt_q] <= y_i;
      end
   end

endmodule

// File: rtl/cc_arbiter.sv
// Arbitrates two buffered requesters onto one coordinate
// engine and routes the result stream back to the owner.
module cc_arbiter
   import cc_arb_pkg::*;
#(
   parameter int TIMEOUT = 1000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req0_valid,
   input  logic [MODE_W-1:0]  req0_mode,
   input  logic [COORD_W-1:0] req0_x,
   input  logic [COORD_W-1:0] req0_y,
   output logic               req0_ready,
   input  logic               req1_valid,
   input  logic [MODE_W-1:0]  req1_mode,
   input  logic [COORD_W-1:0] req1_x,
   input  logic [COORD_W-1:0] req1_y,
   output logic               req1_ready,
   output logic               cc_in_valid,
   output logic [MODE_W-1:0]  cc_mode,
   output logic [COORD_W-1:0] cc_xi,
   output logic [COORD_W-1:0] cc_yi,
   input  logic               cc_out_valid,
   input  logic [COORD_W-1:0] cc_xo,
   input  logic [COORD_W-1:0] cc_yo,
   output logic               rsp_valid,
   output logic               rsp_id,
   output logic [COORD_W-1:0] rsp_x,
   output logic [COORD_W-1:0] rsp_y,
   output logic               err_timeout
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   state_e             state_q;
   logic               grant_q;
   logic               last_q;
   logic [IDX_W-1:0]   idx_q;
   logic [TMO_W-1:0]   tmo_q;

   logic               full0, full1;
   logic [MODE_W-1:0]  mode0, mode1;
   logic [COORD_W-1:0] x0, y0, x1, y1;
   logic [IDX_W-1:0]   rd_idx;
   logic               pick, sel, done;
   logic               free0, free1;
   logic [MODE_W-1:0]  cur_mode;
   logic [COORD_W-1:0] cur_x, cur_y;

   req_buffer u_buf0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_i  (req0_valid),
      .mode_i   (req0_mode),
      .x_i      (req0_x),
      .y_i      (req0_y),
      .free_i   (free0),
      .rd_idx_i (rd_idx),
      .ready_o  (req0_ready),
      .full_o   (full0),
      .mode_o   (mode0),
      .rd_x_o   (x0),
      .rd_y_o   (y0)
   );

   req_buffer u_buf1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_i  (req1_valid),
      .mode_i   (req1_mode),
      .x_i      (req1_x),
      .y_i      (req1_y),
      .free_i   (free1),
      .rd_idx_i (rd_idx),
      .ready_o  (req1_ready),
      .full_o   (full1),
      .mode_o   (mode1),
      .rd_x_o   (x1),
      .rd_y_o   (y1)
   );

   // IDLE reads beat 0 of the winner; ISSUE prefetches the next beat
   assign pick     = rr_pick(full0, full1, last_q);
   assign sel      = (state_q == ST_IDLE) ? pick : grant_q;
   assign rd_idx   = (state_q == ST_IDLE) ? '0 : idx_q + 1'b1;
   assign cur_mode = sel ? mode1 : mode0;
   assign cur_x    = sel ? x1 : x0;
   assign cur_y    = sel ? y1 : y0;

   // Job ends on stream end or on the last silent WAIT cycle
   assign done  = !cc_out_valid &&
                  ((state_q == ST_STREAM) ||
                   ((state_q == ST_WAIT) && (tmo_q == TMO_LAST)));
   assign free0 = done && !grant_q;
   assign free1 = done && grant_q;

   // Arbiter FSM with registered engine and response outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         grant_q     <= 1'b0;
         last_q      <= 1'b1;
         idx_q       <= '0;
         tmo_q       <= '0;
         cc_in_valid <= 1'b0;
         cc_mode     <= '0;
         cc_xi       <= '0;
         cc_yi       <= '0;
         rsp_valid   <= 1'b0;
         rsp_id      <= 1'b0;
         rsp_x       <= '0;
         rsp_y       <= '0;
         err_timeout <= 1'b0;
      end else begin
         cc_in_valid <= 1'b0;
         cc_mode     <= '0;
         cc_xi       <= '0;
         cc_yi       <= '0;
         rsp_valid   <= 1'b0;
         rsp_id      <= 1'b0;
         rsp_x       <= '0;
         rsp_y       <= '0;
         err_timeout <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (full0 || full1) begin
                  grant_q     <= pick;
                  idx_q       <= '0;
                  state_q     <= ST_ISSUE;
                  cc_in_valid <= 1'b1;
                  cc_mode     <= cur_mode;
                  cc_xi       <= cur_x;
                  cc_yi       <= cur_y;
               end
            end
            ST_ISSUE: begin
               if (idx_q == IDX_W'(BEATS - 1)) begin
                  tmo_q   <= '0;
                  state_q <= ST_WAIT;
               end else begin
                  idx_q       <= idx_q + 1'b1;
                  cc_in_valid <= 1'b1;
                  cc_mode     <= cur_mode;
                  cc_xi       <= cur_x;
                  cc_yi       <= cur_y;
               end
            end
            ST_WAIT: begin
               if (cc_out_valid) begin
                  state_q   <= ST_STREAM;
                  rsp_valid <= 1'b1;
                  rsp_id    <= grant_q;
                  rsp_x     <= cc_xo;
                  rsp_y     <= cc_yo;
               end else if (tmo_q == TMO_LAST) begin
                  err_timeout <= 1'b1;
                  state_q     <= ST_IDLE;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            ST_STREAM: begin
               if (cc_out_valid) begin
                  rsp_valid <= 1'b1;
                  rsp_id    <= grant_q;
                  rsp_x     <= cc_xo;
                  rsp_y     <= cc_yo;
               end else begin
                  last_q  <= grant_q;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cc_arbiter.sv
// Self-checking bench for cc_arbiter: job table, engine model,
// scoreboards for engine beats and forwarded responses.
module tb_cc_arbiter;

   localparam int TO = 10;

   typedef struct packed {
      logic [1:0] mode;
      logic [7:0] x;
      logic [7:0] y;
   } cc_beat_t;

   typedef struct packed {
      logic       id;
      logic [7:0] x;
      logic [7:0] y;
      int         cyc;
   } rsp_t;

   typedef struct packed {
      logic       id;
      int         delay;
      int         len;
      logic [7:0] rx;
      logic [7:0] ry;
      logic       silent;
   } eng_t;

   typedef struct packed {
      logic            req;
      logic [1:0]      mode;
      logic [3:0][7:0] xs;
      logic [3:0][7:0] ys;
      int              delay;
      int              len;
      logic [7:0]      rx;
      logic [7:0]      ry;
      logic            exp_id;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0_valid, req1_valid;
   logic [1:0] req0_mode, req1_mode;
   logic [7:0] req0_x, req0_y, req1_x, req1_y;
   logic       req0_ready, req1_ready;
   logic       cc_in_valid;
   logic [1:0] cc_mode;
   logic [7:0] cc_xi, cc_yi;
   logic       cc_out_valid;
   logic [7:0] cc_xo, cc_yo;
   logic       rsp_valid, rsp_id;
   logic [7:0] rsp_x, rsp_y;
   logic       err_timeout;

   cc_arbiter #(.TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req0_valid   (req0_valid),
      .req0_mode    (req0_mode),
      .req0_x       (req0_x),
      .req0_y       (req0_y),
      .req0_ready   (req0_ready),
      .req1_valid   (req1_valid),
      .req1_mode    (req1_mode),
      .req1_x       (req1_x),
      .req1_y       (req1_y),
      .req1_ready   (req1_ready),
      .cc_in_valid  (cc_in_valid),
      .cc_mode      (cc_mode),
      .cc_xi        (cc_xi),
      .cc_yi        (cc_yi),
      .cc_out_valid (cc_out_valid),
      .cc_xo        (cc_xo),
      .cc_yo        (cc_yo),
      .rsp_valid    (rsp_valid),
      .rsp_id       (rsp_id),
      .rsp_x        (rsp_x),
      .rsp_y        (rsp_y),
      .err_timeout  (err_timeout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int cc_cnt = 0;
   int jobs_issued = 0;
   int jobs_served = 0;
   int last_issue_cyc = 0;
   int err_seen = 0;
   logic err_allowed = 1'b0;
   logic eng_abort = 1'b0;
   logic eng_busy = 1'b0;
   logic model_last = 1'b1;

   cc_beat_t exp_cc[$];
   rsp_t     rsp_q[$];
   eng_t     eng_q[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic rdy(input logic r);
      return r ? req1_ready : req0_ready;
   endfunction

   function automatic vec_t mkv(input logic r, input logic [1:0] m,
                                input logic [31:0] xs, input logic [31:0] ys,
                                input int d, input int l,
                                input logic [7:0] rx, input logic [7:0] ry);
      vec_t v;
      v.req = r; v.mode = m; v.xs = xs; v.ys = ys;
      v.delay = d; v.len = l; v.rx = rx; v.ry = ry;
      v.exp_id = r;
      return v;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Monitor: engine-beat and response scoreboards, stray errors
   initial begin
      cc_beat_t eb;
      rsp_t     er;
      forever begin
         @(negedge clk);
         if (rst_n && cc_in_valid) begin
            if (exp_cc.size() == 0) begin
               checks++; failures++;
               $display("FAIL cc_unexpected: got m=%0d x=%0h y=%0h expected none",
                        cc_mode, cc_xi, cc_yi);
            end else begin
               eb = exp_cc.pop_front();
               chk("cc_beat", 32'({cc_mode, cc_xi, cc_yi}), 32'(eb));
            end
            cc_cnt++;
            if (cc_cnt == 4) begin
               cc_cnt = 0;
               jobs_issued++;
               last_issue_cyc = cyc;
            end
         end
         if (rst_n && rsp_valid) begin
            if (rsp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL rsp_unexpected: got id=%0d x=%0h y=%0h expected none",
                        rsp_id, rsp_x, rsp_y);
            end else begin
               er = rsp_q.pop_front();
               chk("rsp_data", 32'({rsp_id, rsp_x, rsp_y}),
                   32'({er.id, er.x, er.y}));
               chk("rsp_cycle", cyc, er.cyc);
            end
         end
         if (err_timeout) begin
            if (err_allowed) err_seen++;
            else begin
               checks++; failures++;
               $display("FAIL err_unexpected: got 1 expected 0");
            end
         end
      end
   end

   // Engine model: answers each issued job per its queued config
   initial begin
      eng_t c;
      rsp_t r;
      cc_out_valid = 1'b0; cc_xo = '0; cc_yo = '0;
      forever begin
         @(posedge clk);
         if (jobs_issued > jobs_served) begin
            jobs_served++;
            if (eng_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL eng_unexpected: got job %0d expected none", jobs_served);
            end else begin
               c = eng_q.pop_front();
               if (!c.silent) begin
                  eng_busy = 1'b1;
                  repeat (c.delay - 1) @(posedge clk);
                  for (int i = 0; i < c.len; i++) begin
                     #1;
                     if (eng_abort) break;
                     cc_out_valid = 1'b1;
                     cc_xo = c.rx + 8'(i);
                     cc_yo = c.ry + 8'(i);
                     r.id = c.id; r.x = cc_xo; r.y = cc_yo; r.cyc = cyc + 1;
                     rsp_q.push_back(r);
                     @(posedge clk);
                  end
                  #1;
                  cc_out_valid = 1'b0; cc_xo = '0; cc_yo = '0;
                  eng_busy = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic set_req(input logic r, input logic v, input logic [1:0] m,
                          input logic [7:0] x, input logic [7:0] y);
      if (r) begin
         req1_valid = v; req1_mode = m; req1_x = x; req1_y = y;
      end else begin
         req0_valid = v; req0_mode = m; req0_x = x; req0_y = y;
      end
   endtask

   task automatic drive_job(input logic r, input logic [1:0] m,
                            input logic [3:0][7:0] xs,
                            input logic [3:0][7:0] ys, input int nb);
      for (int i = 0; i < nb; i++) begin
         @(posedge clk); #1;
         set_req(r, 1'b1, m, xs[i], ys[i]);
      end
      @(posedge clk); #1;
      set_req(r, 1'b0, 2'd0, 8'd0, 8'd0);
   endtask

   task automatic push_expect(input vec_t v, input logic silent);
      cc_beat_t b;
      eng_t     e;
      for (int i = 0; i < 4; i++) begin
         b.mode = v.mode; b.x = v.xs[i]; b.y = v.ys[i];
         exp_cc.push_back(b);
      end
      e.id = v.exp_id; e.delay = v.delay; e.len = v.len;
      e.rx = v.rx; e.ry = v.ry; e.silent = silent;
      eng_q.push_back(e);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!(exp_cc.size() == 0 && eng_q.size() == 0 &&
               !eng_busy && rsp_q.size() == 0)) begin
         @(negedge clk);
         n++;
         if (n > budget) begin
            checks++; failures++;
            $display("FAIL wait_done: got timeout after %0d cycles expected idle", n);
            break;
         end
      end
   endtask

   task automatic run_vec(input vec_t v);
      chk("ready_idle", 32'(rdy(v.req)), 32'd1);
      push_expect(v, 1'b0);
      drive_job(v.req, v.mode, v.xs, v.ys, 4);
      @(negedge clk);
      chk("ready_busy", 32'(rdy(v.req)), 32'd0);
      wait_done(300);
      @(negedge clk);
      chk("ready_after", 32'(rdy(v.req)), 32'd1);
      model_last = v.req;
   endtask

   task automatic run_tie(input vec_t a, input vec_t b);
      logic first;
      first = ~model_last;
      chk("tie_ready", 32'({req0_ready, req1_ready}), 32'd3);
      if (first) begin
         push_expect(b, 1'b0); push_expect(a, 1'b0);
      end else begin
         push_expect(a, 1'b0); push_expect(b, 1'b0);
      end
      fork
         drive_job(1'b0, a.mode, a.xs, a.ys, 4);
         drive_job(1'b1, b.mode, b.xs, b.ys, 4);
      join
      wait_done(400);
      @(negedge clk);
      chk("tie_ready_after", 32'({req0_ready, req1_ready}), 32'd3);
      model_last = ~first;
   endtask

   initial begin
      vec_t vt[5];
      vec_t vr;
      logic ok;
      int   n;
      vt[0] = mkv(1'b0, 2'd1, 32'h07050301, 32'h08060402, 3, 1, 8'h09, 8'h09);
      vt[1] = mkv(1'b1, 2'd2, 32'h44332211, 32'h88776655, 2, 3, 8'h20, 8'h30);
      vt[2] = mkv(1'b0, 2'd3, 32'h0D0C0B0A, 32'h1D1C1B1A, 4, 6, 8'h40, 8'h50);
      vt[3] = mkv(1'b1, 2'd0, 32'hFFFE0100, 32'h7F80FF00, 1, 2, 8'hFF, 8'h0F);
      vt[4] = mkv(1'b0, 2'd2, 32'h01020304, 32'h05060708, 10, 1, 8'hA5, 8'h5A);

      rst_n = 1'b0;
      set_req(1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
      set_req(1'b1, 1'b0, 2'd0, 8'd0, 8'd0);
      @(negedge clk);
      chk("reset_cc", 32'({cc_in_valid, cc_mode, cc_xi, cc_yi}), 32'd0);
      chk("reset_rsp", 32'({rsp_valid, rsp_id, rsp_x, rsp_y, err_timeout}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_ready", 32'({req0_ready, req1_ready}), 32'd3);

      foreach (vt[k]) run_vec(vt[k]);

      // Partial job: two beats then valid drops
      chk("partial_ready0", 32'(req1_ready), 32'd1);
      drive_job(1'b1, 2'd3, 32'hDEADBEEF, 32'hCAFEF00D, 2);
      ok = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (!req1_ready || cc_in_valid) ok = 1'b0;
      end
      chk("partial_no_job", 32'(ok), 32'd1);
      run_vec(vt[1]);

      run_tie(vt[0], vt[1]);
      run_tie(vt[2], vt[3]);

      // Silent engine: abort after TO cycles in WAIT
      err_allowed = 1'b1;
      err_seen = 0;
      push_expect(vt[0], 1'b1);
      drive_job(1'b0, vt[0].mode, vt[0].xs, vt[0].ys, 4);
      n = 0;
      while (!err_timeout && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("err_cycle", cyc, last_issue_cyc + TO + 1);
      chk("err_freed", 32'(req0_ready), 32'd1);
      @(negedge clk);
      chk("err_pulse", 32'(err_timeout), 32'd0);
      err_allowed = 1'b0;
      chk("err_count", err_seen, 1);
      run_vec(vt[2]);

      // Reset in the middle of a stream
      vr = mkv(1'b0, 2'd1, 32'h11121314, 32'h21222324, 2, 8, 8'h60, 8'h70);
      push_expect(vr, 1'b0);
      drive_job(1'b0, vr.mode, vr.xs, vr.ys, 4);
      n = 0;
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("rst_in_stream", 32'(rsp_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      eng_abort = 1'b1;
      #1;
      chk("rst_cc_zero", 32'({cc_in_valid, cc_mode, cc_xi, cc_yi}), 32'd0);
      chk("rst_rsp_zero", 32'({rsp_valid, rsp_id, rsp_x, rsp_y, err_timeout}), 32'd0);
      exp_cc.delete();
      rsp_q.delete();
      cc_cnt = 0;
      model_last = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      eng_abort = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd3);
      repeat (10) @(negedge clk);
      run_vec(vt[0]);

      chk("drain", exp_cc.size() + rsp_q.size() + eng_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cc_arbiter.md
CC_ARBITER -- requirements
Module: cc_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1000: max cycles in WAIT before abort.
REQ-002 clk  input  1  single clock; all flops rising-edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 reqN_valid (N=0,1)  input  1  requester N beat valid.
REQ-005 reqN_mode  input  2  job mode; sampled on beat 0 only.
REQ-006 reqN_x, reqN_y  input  8 each  coordinate pair of current beat.
REQ-007 reqN_ready  output  1  high while requester N's buffer is empty and not under service.
REQ-008 cc_in_valid, cc_mode[1:0], cc_xi[7:0], cc_yi[7:0]  outputs  engine drive.
REQ-009 cc_out_valid, cc_xo[7:0], cc_yo[7:0]  inputs  engine result stream.
REQ-010 rsp_valid 1, rsp_id 1, rsp_x 8, rsp_y 8  outputs  forwarded result plus owning requester.
REQ-011 err_timeout  output  1  one-cycle pulse on WAIT abort.

Function
REQ-012 A job is exactly 4 beats on consecutive cycles with reqN_valid high while reqN_ready high; beats stored in requester N's 4-entry buffer.
REQ-013 reqN_valid dropping before beat 4 discards the partial job; beat counter returns to 0; buffer stays empty.
REQ-014 Buffer marked full on 4th beat; reqN_ready low from the next cycle until job completes.
REQ-015 States: IDLE, ISSUE, WAIT, STREAM.
REQ-016 IDLE: if any buffer full, grant round-robin (favour the requester not granted last; last_grant resets to 1 so req0 wins first tie), go ISSUE.
REQ-017 ISSUE: 4 cycles, cc_in_valid=1, cc_xi/cc_yi = buffer beats 0..3 in order, cc_mode = stored mode constant all 4 cycles; first issue beat is the cycle after the IDLE grant; then WAIT.
REQ-018 WAIT: on cc_out_valid=1 go STREAM; after TIMEOUT cycles without it, pulse err_timeout, free granted buffer, go IDLE.
REQ-019 STREAM: each cycle cc_out_valid=1, register cc_xo/cc_yo onto rsp_x/rsp_y with rsp_valid=1, rsp_id=grant, one cycle latency; first cc_out_valid cycle (WAIT->STREAM) is also forwarded.
REQ-020 STREAM ends on first cycle cc_out_valid=0: free granted buffer, update last_grant, go IDLE; variable stream length (>=1) supported.
REQ-021 cc_out_valid in IDLE or ISSUE ignored, not forwarded.
REQ-022 Non-granted requester may load its buffer during any state; loads into the granted buffer impossible (ready low).
REQ-023 All outputs registered; cc_in_valid, rsp_valid, err_timeout low outside their states; data outputs 0 when their valid is low.
REQ-024 Minimum back-to-back spacing: IDLE one cycle between jobs.

Reset
REQ-025 rst_n low: state IDLE, buffers empty, beat counters 0, last_grant=1, timeout counter 0, all outputs 0 except reqN_ready=1 (from first cycle after release).
REQ-026 Reset mid-operation aborts job silently; no err_timeout, no rsp.

Structure
REQ-027 Package cc_arb_pkg: state enum, BEATS=4, MODE_W=2, COORD_W=8.
REQ-028 Sub-module req_buffer (4-entry beat store, counter, mode latch, full flag, partial discard) instantiated twice.

Verification
REQ-029 req0 job mode=1, beats (1,2),(3,4),(5,6),(7,8); engine model returns 1 beat (9,9) 3 cycles later -> cc beats in order mode 1, rsp_valid 1 cycle, rsp_id=0, (9,9).
REQ-030 Both requesters load jobs same cycles -> req0 served first, then req1; req1 rsp_id=1; next tie goes to req0 after req1.
REQ-031 Engine returns 6-beat stream -> 6 consecutive rsp beats, values match, req0_ready rises after stream ends.
REQ-032 req1 drops valid after 2 beats -> no job, req1_ready stays 1, engine untouched.
REQ-033 TIMEOUT=10, engine silent -> err_timeout pulse exactly 10 cycles into WAIT, buffer freed, next job serviced normally.
REQ-034 rst_n asserted during STREAM -> all outputs 0 immediately, both ready=1 after release, no stale rsp.
